pll_reset_sequencer: RTL and testbench

- Controls the reset side of a core PLL: drives the PLL's active-high `rst` input and monitors its `locked` output.
- Produces a glitch-free core reset that releases only after a lock that is continuously stable.
- Runs on the 50 MHz board reference clock, which is always present, so it keeps working while the PLL outputs are absent.
- Re-sequences the PLL on lock timeout, on loss of lock, or on host request (e.g. after a video-mode PLL change).

---
 rtl/pll_reset_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a lock that stays
// stable, then releases the core reset. It re-sequences on lock timeout, on
// loss of lock in RUN, or on a host force_relock request. Runs on refclk only.
// Optional build macro PLL_RETRY_LIMIT_EN: after MAX_RETRIES failed lock
// attempts the sequencer parks in FAIL until rst_n.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic [2:0] retry_cnt,
  output logic [7:0] lost_cnt,
  output logic       pll_fail,
  output logic [2:0] state
);

  // One shared phase counter; it must hold the largest phase length.
  localparam int M1      = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (M1 > STABLE_CYCLES) ? M1 : STABLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [2:0]    RETRY_LIMIT = 3'(MAX_RETRIES);

`ifdef PLL_RETRY_LIMIT_EN
  localparam bit FAIL_EN = 1'b1;
`else
  localparam bit FAIL_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             retry_q, retry_d, retry_inc;
  logic [7:0]             lost_q, lost_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   pll_rst_q, core_reset_q, ready_q;

  assign locked_s  = sync_q[SYNC_STAGES-1];
  assign retry_inc = (retry_q == 3'd7) ? 3'd7 : retry_q + 3'd1;

  // Synchronise the asynchronous PLL lock flag into refclk.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  // State, phase counter, event counters and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_PLLRST;
      cnt_q        <= '0;
      retry_q      <= '0;
      lost_q       <= '0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      lost_q       <= lost_d;
      pll_rst_q    <= (state_d == S_PLLRST) || (state_d == S_FAIL);
      core_reset_q <= (state_d != S_RUN);
      ready_q      <= (state_d == S_RUN);
    end
  end

  // Next-state logic; force_relock outranks lock loss and timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    if (force_relock && (state_q != S_FAIL)) begin
      state_d = S_PLLRST;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_PLLRST: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT: begin
          if (locked_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            cnt_d   = '0;
            retry_d = retry_inc;
            if (FAIL_EN && (retry_inc >= RETRY_LIMIT)) state_d = S_FAIL;
            else                                       state_d = S_PLLRST;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_STABLE: begin
          // A drop on the final count cycle still aborts the release.
          if (!locked_s) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_d = S_PLLRST;
            cnt_d   = '0;
            lost_d  = (lost_q == 8'hFF) ? 8'hFF : lost_q + 8'd1;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_PLLRST;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef PLL_RETRY_LIMIT_EN
  logic pll_fail_q;

  // FAIL flag, registered alongside the other outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) pll_fail_q <= 1'b0;
    else        pll_fail_q <= (state_d == S_FAIL);
  end

  assign pll_fail = pll_fail_q;
`else
  assign pll_fail = 1'b0;
`endif

  assign pll_rst    = pll_rst_q;
  assign core_reset = core_reset_q;
  assign ready      = ready_q;
  assign retry_cnt  = retry_q;
  assign lost_cnt   = lost_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock/relock
// traffic. A behavioural model predicts every post-edge output set; a monitor
// pops and compares one prediction per clock.
module tb_pll_reset_sequencer;
  localparam int RSTC = 4, TMO = 32, STB = 8, MAXR = 2, SYNC = 2;

`ifdef PLL_RETRY_LIMIT_EN
  localparam bit M_FAIL_EN = 1'b1;
`else
  localparam bit M_FAIL_EN = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst, core_reset, ready, pll_fail;
  logic [2:0] retry_cnt, state;
  logic [7:0] lost_cnt;

  pll_reset_sequencer #(
    .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TMO), .STABLE_CYCLES(STB),
    .MAX_RETRIES(MAXR), .SYNC_STAGES(SYNC)
  ) u_dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked),
    .force_relock(force_relock), .pll_rst(pll_rst), .core_reset(core_reset),
    .ready(ready), .retry_cnt(retry_cnt), .lost_cnt(lost_cnt),
    .pll_fail(pll_fail), .state(state)
  );

  always #10 refclk = ~refclk;

  typedef struct packed {
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic       pll_fail;
    logic [2:0] retry;
    logic [2:0] state;
    logic [7:0] lost;
  } obs_t;

  int   total = 0;
  int   bad = 0;
  obs_t exp_q[$];

  // Behavioural model: phase number, cycles spent in phase, event counts,
  // and the lock flag as seen SYNC cycles late.
  int m_ph, m_el, m_retry, m_lost;
  bit m_sync[$];

  function automatic void m_reset();
    m_ph = 0; m_el = 0; m_retry = 0; m_lost = 0;
    m_sync = {};
    for (int i = 0; i < SYNC; i++) m_sync.push_back(1'b0);
  endfunction

  function automatic void m_step(bit lk, bit fr);
    bit ls;
    ls = m_sync[0];
    if (fr && m_ph != 4) begin
      m_ph = 0; m_el = 0;
    end else begin
      case (m_ph)
        0: begin
          m_el++;
          if (m_el == RSTC) begin m_ph = 1; m_el = 0; end
        end
        1: begin
          if (ls) begin
            m_ph = 2; m_el = 0;
          end else begin
            m_el++;
            if (m_el == TMO) begin
              m_retry = (m_retry < 7) ? m_retry + 1 : 7;
              m_ph = (M_FAIL_EN && m_retry >= MAXR) ? 4 : 0;
              m_el = 0;
            end
          end
        end
        2: begin
          if (!ls) begin
            m_ph = 1; m_el = 0;
          end else begin
            m_el++;
            if (m_el == STB) begin m_ph = 3; m_el = 0; m_retry = 0; end
          end
        end
        3: begin
          if (!ls) begin
            m_ph = 0; m_el = 0;
            m_lost = (m_lost < 255) ? m_lost + 1 : 255;
          end
        end
        default: ;
      endcase
    end
    void'(m_sync.pop_front());
    m_sync.push_back(lk);
  endfunction

  function automatic obs_t m_out();
    obs_t o;
    o.pll_rst    = (m_ph == 0) || (m_ph == 4);
    o.core_reset = (m_ph != 3);
    o.ready      = (m_ph == 3);
    o.pll_fail   = (m_ph == 4);
    o.retry      = 3'(m_retry);
    o.state      = 3'(m_ph);
    o.lost       = 8'(m_lost);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.pll_rst = pll_rst; o.core_reset = core_reset; o.ready = ready;
    o.pll_fail = pll_fail; o.retry = retry_cnt; o.state = state;
    o.lost = lost_cnt;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one prediction per clock edge, compared after the edge settles.
  task automatic monitor();
    obs_t e, a;
    forever begin
      @(posedge refclk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = dut_obs();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle_obs t=%0t got %h expected %h", $time, a, e);
        end
      end
    end
  endtask

  // Called at a negedge: drive inputs, predict, advance to next negedge.
  task automatic step(input bit lk, input bit fr);
    pll_locked   = lk;
    force_relock = fr;
    m_step(lk, fr);
    exp_q.push_back(m_out());
    @(negedge refclk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_ready", ready, 0);
    chk("rst_pll_fail", pll_fail, 0);
    chk("rst_state", state, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_lost", lost_cnt, 0);
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic to_run();
    int k;
    k = 0;
    while (!ready && k < 200) begin step(1, 0); k++; end
    chk("to_run_reached", ready, 1);
  endtask

  initial begin
    int hi, last_hi, fall, n, lb, rb, k;
    bit saw_rst, saw_wait, lk, fr;
    fork monitor(); join_none
    m_reset();
    repeat (3) @(negedge refclk);
    do_reset();

    // Power-up: lock rises in cycle 10.
    hi = 0; last_hi = 0; fall = 0;
    for (int c = 1; c <= 26; c++) begin
      if (pll_rst) begin hi++; last_hi = c; end
      if (!core_reset && fall == 0) fall = c;
      step(c >= 10, 0);
    end
    chk("pwr_pll_rst_cycles", hi, 4);
    chk("pwr_pll_rst_last", last_hi, 4);
    chk("pwr_core_fall_cycle", fall, 21);
    chk("pwr_ready", ready, 1);
    chk("pwr_retry", retry_cnt, 0);

    // Loss in RUN: core_reset and pll_rst rise 3 cycles after the drop.
    step(0, 0);
    n = 1;
    while (!core_reset && n < 10) begin step(0, 0); n++; end
    chk("loss_latency", n, 3);
    chk("loss_pll_rst", pll_rst, 1);
    chk("loss_lost_cnt", lost_cnt, 1);

    // force_relock in RUN.
    to_run();
    lb = lost_cnt;
    step(1, 1);
    chk("relock_state", state, 0);
    chk("relock_core_reset", core_reset, 1);
    chk("relock_lost", lost_cnt, lb);

    // force_relock coincident with the synchronised lock drop.
    to_run();
    lb = lost_cnt;
    step(0, 0); step(0, 0); step(0, 1);
    chk("relock_drop_state", state, 0);
    chk("relock_drop_lost", lost_cnt, lb);

    // One-cycle lock glitch a few cycles into STABLE.
    do_reset();
    k = 0;
    while (!(m_ph == 2 && m_el == 3) && k < 100) begin step(1, 0); k++; end
    rb = retry_cnt;
    step(0, 0);
    saw_rst = 0; saw_wait = 0; k = 0;
    while (!ready && k < 100) begin
      if (pll_rst) saw_rst = 1;
      if (state == 3'd1) saw_wait = 1;
      step(1, 0); k++;
    end
    chk("glitch_saw_wait", saw_wait, 1);
    chk("glitch_no_pll_rst", saw_rst, 0);
    chk("glitch_retry", retry_cnt, rb);
    chk("glitch_ready", ready, 1);

    // Lock drop landing on the final STABLE count cycle: no RUN entry.
    do_reset();
    k = 0;
    while (!(m_ph == 2 && m_el == STB - 1 - SYNC) && k < 100) begin step(1, 0); k++; end
    step(0, 0); step(1, 0);
    chk("final_cnt_pre_state", state, 2);
    step(1, 0);
    chk("final_cnt_state", state, 1);
    chk("final_cnt_ready", ready, 0);

    // Lock timeout with pll_locked held low.
    do_reset();
    repeat (36) step(0, 0);
    chk("tmo1_retry", retry_cnt, 1);
    chk("tmo1_state", state, 0);
    chk("tmo1_pll_rst", pll_rst, 1);
    repeat (36) step(0, 0);
`ifdef PLL_RETRY_LIMIT_EN
    chk("fail_state", state, 4);
    chk("fail_flag", pll_fail, 1);
    chk("fail_retry", retry_cnt, 2);
    step(0, 1); step(0, 1);
    chk("fail_ignores_relock", state, 4);
    chk("fail_pll_rst", pll_rst, 1);
    do_reset();
`else
    chk("tmo2_retry", retry_cnt, 2);
    chk("tmo2_state", state, 0);
    repeat (36 * 6) step(0, 0);
    chk("tmo_sat_retry", retry_cnt, 7);
    repeat (36) step(0, 0);
    chk("tmo_sat_hold", retry_cnt, 7);
    chk("tmo_no_fail", pll_fail, 0);
`endif

    // lost_cnt saturation.
    do_reset();
    to_run();
    for (int i = 0; i < 260; i++) begin
      step(0, 0); step(1, 0); step(1, 0);
      to_run();
    end
    chk("lost_saturate", lost_cnt, 255);

    // Random lock behaviour, relock requests and occasional resets.
    do_reset();
    lk = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29) == 0) lk = ~lk;
      fr = ($urandom_range(99) == 0);
      if ($urandom_range(699) == 0) do_reset();
      else step(lk, fr);
    end

    @(negedge refclk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
